// File: rtl/producto_pkg.sv
// Shared definitions for the binary-to-BCD converter of the multiplier product.
package producto_pkg;

    localparam int BITS_PRODUCTO = 17;
    localparam int DIGITOS_BCD   = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module ajuste_bcd (
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);

    // Add 3 to digits that would overflow past 9 once doubled by the shift
    always_comb begin
        digito_o = (digito_i >= 4'd5) ? digito_i + 4'd3 : digito_i;
    end

endmodule

// File: rtl/producto_bcd.sv
// Sequential double-dabble converter: one shift-and-adjust iteration per clock,
// BITS iterations per conversion, result held on bcd until the next completion.
module producto_bcd
    import producto_pkg::*;
#(
    parameter int BITS   = BITS_PRODUCTO,
    parameter int DIGITS = DIGITOS_BCD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BITS-1:0]       producto,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(BITS + 1);
    localparam int SW    = 4 * DIGITS;

    estado_t           state_q, state_d;
    logic [BITS-1:0]   bin_q, bin_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic [SW-1:0]     ajustado;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW+BITS-1:0] desplazado;
    logic              ultima;

    // One correction cell per scratch digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .digito_i (scratch_q[4*g +: 4]),
            .digito_o (ajustado[4*g +: 4])
        );
    end

    // Counter at 1 means this edge performs the last iteration
    assign ultima = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at outside SHIFT
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (ultima) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: capture on accepted start, shift-and-adjust while converting
    always_comb begin
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        desplazado = {ajustado, bin_q} << 1;
        case (state_q)
            SHIFT: begin
                {scratch_d, bin_d} = desplazado;
                cnt_d              = cnt_q - CNT_W'(1);
                if (ultima) begin
                    bcd_d = desplazado[SW+BITS-1:BITS];
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    bin_d     = producto;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BITS);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything, aborting any conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    // Outputs decoded from state; bcd is the held result register
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        bcd  = bcd_q;
    end

endmodule

// File: tb/tb_producto_bcd.sv
// Directed bench for producto_bcd: latency, values, back-to-back, ignored start, reset abort.
module tb_producto_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] producto;
    logic [23:0] bcd;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int edges;
    int busy_cycles;
    int pulses;

    always #5 clk = ~clk;

    producto_bcd #(
        .BITS   (17),
        .DIGITS (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .producto (producto),
        .bcd      (bcd),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [16:0] val);
        producto = val;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = 0;
        while (done !== 1'b1 && n_edges < 40) begin
            if (busy === 1'b1) n_busy++;
            step();
            n_edges++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    function automatic logic nibbles_ok(input logic [23:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        producto = '0;
        #2;
        check("rst_bcd",  {8'd0, bcd}, 32'h000000);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 255*255, latency and busy duration
        launch(17'd65025);
        check("65025_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(edges, busy_cycles);
        check("65025_latency", edges + 1, 32'd18);
        check("65025_busy_cycles", busy_cycles, 32'd17);
        check("65025_bcd", {8'd0, bcd}, 32'h065025);
        check("65025_busy_at_done", {31'd0, busy}, 32'd0);
        step();
        check("65025_done_one_cycle", {31'd0, done}, 32'd0);
        check("65025_bcd_hold", {8'd0, bcd}, 32'h065025);

        // Range endpoints and a single digit
        launch(17'd0);
        wait_done(edges, busy_cycles);
        check("zero_bcd", {8'd0, bcd}, 32'h000000);
        step();
        launch(17'd131071);
        wait_done(edges, busy_cycles);
        check("max_bcd", {8'd0, bcd}, 32'h131071);
        check("max_nibbles", {31'd0, nibbles_ok(bcd)}, 32'd1);
        step();
        launch(17'd9);
        wait_done(edges, busy_cycles);
        check("nine_bcd", {8'd0, bcd}, 32'h000009);
        step();

        // Start and producto change during a conversion are ignored
        launch(17'd12345);
        repeat (4) step();
        start    = 1'b1;
        producto = 17'd999;
        check("mid_bcd_held", {8'd0, bcd}, 32'h000009);
        step();
        start = 1'b0;
        check("mid_still_busy", {31'd0, busy}, 32'd1);
        wait_done(edges, busy_cycles);
        check("mid_latency", edges + 5, 32'd17);
        check("mid_bcd", {8'd0, bcd}, 32'h012345);
        step();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            step();
        end
        check("mid_no_second_conv", pulses, 32'd0);

        // Reset mid-conversion aborts immediately
        launch(17'd500);
        repeat (7) step();
        rst = 1'b1;
        #1;
        check("abort_bcd", {8'd0, bcd}, 32'h000000);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        pulses = 0;
        step();
        if (done === 1'b1) pulses++;
        step();
        if (done === 1'b1) pulses++;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            step();
        end
        check("abort_no_done", pulses, 32'd0);
        check("abort_bcd_after", {8'd0, bcd}, 32'h000000);
        launch(17'd42);
        wait_done(edges, busy_cycles);
        check("after_abort_latency", edges + 1, 32'd18);
        check("after_abort_bcd", {8'd0, bcd}, 32'h000042);
        step();

        // start held high: back-to-back conversions every 18 cycles
        producto = 17'd100;
        start    = 1'b1;
        step();
        producto = 17'd200;
        wait_done(edges, busy_cycles);
        check("b2b_first_latency", edges + 1, 32'd18);
        check("b2b_first_bcd", {8'd0, bcd}, 32'h000100);
        step();
        check("b2b_restart_busy", {31'd0, busy}, 32'd1);
        check("b2b_bcd_held", {8'd0, bcd}, 32'h000100);
        wait_done(edges, busy_cycles);
        check("b2b_period", edges + 1, 32'd18);
        check("b2b_second_bcd", {8'd0, bcd}, 32'h000200);
        start = 1'b0;
        step();
        check("b2b_end_busy", {31'd0, busy}, 32'd0);
        check("b2b_end_done", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
